// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory write path.
`default_nettype none

package mem_pkg;

  localparam int SB_ADDR_W = 32;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           be;
  } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/sb_align.sv
// Combinational lane shifter: moves LSB-justified store data onto its byte lanes.
`default_nettype none

module sb_align (
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] aligned
);

  assign aligned = data << {offset, 3'b000};

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// In-order store buffer between MEM stage and data memory, with load RAW hazard compare.
`default_nettype none

module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_be,
  output logic                     st_err,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hazard,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  generate
    if (ADDR_W != SB_ADDR_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("store_buffer: ADDR_W must match SB_ADDR_W and DEPTH must be a power of two >= 2");
    end
  endgenerate

  sb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [31:0]        aligned;
  logic               full;
  logic               push;
  logic               drop;
  logic               pop;
  logic               unused_ld_lanes;

  sb_align u_align (
    .offset  (st_addr[1:0]),
    .data    (st_data),
    .aligned (aligned)
  );

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full     = (head[IDX_W] != tail[IDX_W]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);
  assign empty    = (head == tail);
  assign count    = tail - head;
  assign st_ready = !full;
  assign push     = st_valid && st_ready && (st_be != BE_NONE);
  assign drop     = st_valid && st_ready && (st_be == BE_NONE);
  assign pop      = mem_req && mem_ack;

  assign mem_req   = !empty;
  assign mem_addr  = entries[head[IDX_W-1:0]].addr;
  assign mem_wdata = entries[head[IDX_W-1:0]].wdata;
  assign mem_be    = entries[head[IDX_W-1:0]].be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= drop;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail[IDX_W-1:0]] <= '{addr:  {st_addr[ADDR_W-1:2], 2'b00},
                                    wdata: aligned,
                                    be:    st_be};
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [IDX_W-1:0] off;
      off = IDX_W'(i) - head[IDX_W-1:0];
      if (({1'b0, off} < count) &&
          (entries[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  assign unused_ld_lanes = ^ld_addr[1:0];

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with an in-order expectation queue.
`default_nettype none

module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sbq[$];

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_be     (st_be),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; scoreboard push on accept, pop/compare on ack.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic ack);
    logic acc;
    logic drop;
    exp_t e;
    st_valid = v; st_addr = a; st_data = d; st_be = b; mem_ack = ack;
    #2;
    chk("st_ready", 64'(st_ready), 64'(sbq.size() < 4));
    if (ack && mem_req) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
        chk("mem_be", 64'(mem_be), 64'(e.be));
      end
    end
    acc  = v && (sbq.size() < 4 || (ack && mem_req && sbq.size() < 4)) && st_ready;
    drop = acc && (b == 4'b0000);
    if (acc && b != 4'b0000) begin
      e.addr = {a[31:2], 2'b00};
      e.data = d << (8 * a[1:0]);
      e.be   = b;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    st_valid = 1'b0; mem_ack = 1'b0;
    chk("st_err", 64'(st_err), 64'(drop));
    chk("count", 64'(count), 64'(sbq.size()));
    chk("mem_req", 64'(mem_req), 64'(sbq.size() != 0));
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sbq.size() != 0; k++) cycle(1'b0, 0, 0, 4'b0000, 1'b1);
    chk("drained_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_st_err", 64'(st_err), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);

    // Single unaligned-lane store
    cycle(1'b1, 32'h1002, 32'h0000ABCD, 4'b1100, 1'b0);
    chk("t1_mem_req", 64'(mem_req), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h1000);
    chk("t1_mem_wdata", 64'(mem_wdata), 64'hABCD0000);
    chk("t1_mem_be", 64'(mem_be), 64'b1100);
    cycle(1'b0, 0, 0, 4'b0000, 1'b1);
    chk("t1_empty", 64'(empty), 64'd1);

    // Ack with nothing pending is ignored
    cycle(1'b0, 0, 0, 4'b0000, 1'b1);
    chk("idle_ack_count", 64'(count), 64'd0);

    // Fill with no acks, then hold a fifth request until space frees
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 32'h11110000 + 32'(i), 4'b1111, 1'b0);
    chk("fill_ready", 64'(st_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd4);
    cycle(1'b1, 32'h10, 32'h55555555, 4'b1111, 1'b0);
    chk("held_count", 64'(count), 64'd4);
    cycle(1'b1, 32'h10, 32'h55555555, 4'b1111, 1'b1);
    chk("held_after_pop", 64'(count), 64'd3);
    cycle(1'b1, 32'h10, 32'h55555555, 4'b1111, 1'b1);
    chk("fifth_accepted", 64'(count), 64'd3);
    drain();

    // Steady push+pop at occupancy 2 across several pointer laps
    cycle(1'b1, 32'h100, 32'hA0A0A0A0, 4'b1111, 1'b0);
    cycle(1'b1, 32'h104, 32'hA1A1A1A1, 4'b0011, 1'b0);
    for (int k = 0; k < 14; k++) begin
      cycle(1'b1, 32'h108 + 32'(4 * k) + 32'(k % 4), $urandom, 4'b0001 << (k % 4), 1'b1);
      chk("steady_count", 64'(count), 64'd2);
    end
    drain();

    // Dropped store: no entry, one-cycle error pulse
    cycle(1'b1, 32'h40, 32'h12345678, 4'b1111, 1'b0);
    cycle(1'b1, 32'h3, 32'hFF, 4'b0000, 1'b0);
    chk("drop_err", 64'(st_err), 64'd1);
    chk("drop_count", 64'(count), 64'd1);
    cycle(1'b0, 0, 0, 4'b0000, 1'b0);
    chk("drop_err_clear", 64'(st_err), 64'd0);
    drain();

    // Load hazard against a pending store
    cycle(1'b1, 32'h2000, 32'hCAFEF00D, 4'b1111, 1'b0);
    ld_addr = 32'h2003; #1;
    chk("hz_same_word", 64'(ld_hazard), 64'd1);
    ld_addr = 32'h2004; #1;
    chk("hz_next_word", 64'(ld_hazard), 64'd0);
    ld_addr = 32'h2003; mem_ack = 1'b1; #1;
    chk("hz_during_ack", 64'(ld_hazard), 64'd1);
    cycle(1'b0, 0, 0, 4'b0000, 1'b1);
    chk("hz_after_pop", 64'(ld_hazard), 64'd0);

    // Async reset mid-cycle with three pending stores and an ack in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 32'(i), 4'b1111, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    mem_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    sbq.delete();
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_ready", 64'(st_ready), 64'd1);
    chk("post_rst_empty", 64'(empty), 64'd1);

    // Buffer is usable after reset
    cycle(1'b1, 32'h501, 32'h000000EE, 4'b0010, 1'b0);
    chk("post_rst_wdata", 64'(mem_wdata), 64'h0000EE00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Small in-order write buffer between the MEM stage and the data-memory port. It accepts one store per cycle carrying the lane mask from the store byte-enable shifter, aligns the store data to those lanes, queues the store, and drains it to memory over a req/ack handshake. The pipeline does not stall on memory latency unless the buffer is full. A load-address compare flags read-after-write hazards against pending stores.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_W, 32, byte-address width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept; equals !full
- st_addr  in  ADDR_W  byte address of store
- st_data  in  32  unaligned store data (rs2 value, LSB-justified)
- st_be  in  4  lane mask from byte-enable shifter; 4'b0000 marks misaligned/illegal
- st_err  out  1  one-cycle pulse, registered, for a dropped store
- mem_req  out  1  head entry valid toward memory
- mem_addr  out  ADDR_W  word address of head; bits [1:0] forced to 0
- mem_wdata  out  32  lane-aligned data of head
- mem_be  out  4  byte enables of head
- mem_ack  in  1  memory accepted head this cycle
- ld_addr  in  ADDR_W  address of the load in MEM stage
- ld_hazard  out  1  combinational; a pending entry matches ld_addr word
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Push: st_valid && st_ready && st_be != 0 writes an entry at the tail.
  - Stored address is {st_addr[ADDR_W-1:2], 2'b00}.
  - Stored be is st_be.
  - Stored data is st_data << (8*st_addr[1:0]), truncated to 32 bits.
- Drop: st_valid && st_ready && st_be == 0 writes no entry. st_err = 1 on the next cycle.
- st_valid while full: not accepted. The upstream holds its request; no error is raised.
- Pop: mem_req && mem_ack advances the head. mem_* always reflect the head entry. mem_req = !empty.
- Simultaneous push and pop: count is unchanged and both pointers advance. With count == DEPTH, st_ready is 0 that cycle, so no pass-through.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the low bits are equal.
- Stores drain strictly in order. Entries are never merged or coalesced.
- ld_hazard = OR over valid entries of (entry addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]). Byte overlap is not checked. An entry popped this cycle still counts.
- mem_ack while mem_req = 0 is ignored.

## Timing
- Reset (async assert, synchronous release on clk):
  - head = tail = 0, count = 0, empty = 1
  - mem_req = 0, st_err = 0, st_ready = 1
  - Entry contents are don't-care.
- Push-to-mem_req latency: 1 cycle. A store accepted at edge N gives mem_req = 1 after edge N when the buffer was empty.
- mem_req and the mem_* payload hold stable until mem_ack. The next entry appears the cycle after the ack.
- Throughput: one push and one pop per cycle.
- Reset mid-drain discards every pending store, including a head that is being acked.

## Structure
- Shared package (mem_pkg):
  - typedef sb_entry_t {addr, wdata, be}
  - BE_NONE = 4'b0000
  - BE_WORD = 4'b1111
- One natural sub-module: sb_align, a combinational lane shifter for st_data by st_addr[1:0].
- Storage is a register array. There is no RAM inference, since ld_hazard needs all entries in parallel.

## Test plan
- Reset then single store:
  - Stimulus: addr 0x1002, data 0x0000ABCD, be 4'b1100.
  - Response: next cycle mem_req = 1, mem_addr 0x1000, mem_wdata 0xABCD0000, mem_be 4'b1100.
  - Ack once, then empty = 1.
- Fill with mem_ack held 0:
  - Stimulus: push 4 word stores at 0x0, 0x4, 0x8, 0xC.
  - Response: st_ready = 0 after the 4th, count = 4.
  - A 5th st_valid is held, not lost. Acks then return 0x0, 0x4, 0x8, 0xC in order, and the 5th is accepted when st_ready rises.
- Simultaneous push and pop at count = 2: count stays 2 and the order is preserved across pointer wrap (at least 3 full laps).
- Misaligned store:
  - Stimulus: be 4'b0000 at addr 0x3.
  - Response: no entry, count unchanged, st_err pulses 1 cycle.
- Hazard:
  - Pending store at 0x2000 with ld_addr 0x2003 gives ld_hazard = 1.
  - ld_addr 0x2004 gives 0.
  - After the ack pops the entry, 0x2003 gives 0.
- Async reset asserted mid-cycle with 3 entries pending: mem_req drops immediately, and after release count = 0, st_ready = 1.
